// File: rtl/pipe_pkg.sv
// Shared widths, the hard-wired zero register and ALU operation encodings
// for the pipelined datapath.
package pipe_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int ALU_OP_WIDTH   = 4;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side, register-file, write-back, control and EX-side signals
// around the ID/EX stage. The slave modport is the stage itself.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
    parameter int ALU_OP_WIDTH   = pipe_pkg::ALU_OP_WIDTH
);

    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [ALU_OP_WIDTH-1:0]   id_alu_op;
    logic                      id_mem_read;
    logic                      id_reg_write;

    logic [REG_ADDR_WIDTH-1:0] rf_read_sel_1;
    logic [REG_ADDR_WIDTH-1:0] rf_read_sel_2;
    logic [DATA_WIDTH-1:0]     rf_read_data_1;
    logic [DATA_WIDTH-1:0]     rf_read_data_2;

    logic                      wb_write_enable;
    logic [REG_ADDR_WIDTH-1:0] wb_write_select;
    logic [DATA_WIDTH-1:0]     wb_write_data;

    logic                      flush;
    logic                      ex_hold;
    logic                      stall;

    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     ex_op_a;
    logic [DATA_WIDTH-1:0]     ex_op_b;
    logic [DATA_WIDTH-1:0]     ex_imm;
    logic [REG_ADDR_WIDTH-1:0] ex_rs;
    logic [REG_ADDR_WIDTH-1:0] ex_rt;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [ALU_OP_WIDTH-1:0]   ex_alu_op;
    logic                      ex_mem_read;
    logic                      ex_reg_write;

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_imm, id_alu_op, id_mem_read, id_reg_write,
        output rf_read_sel_1, rf_read_sel_2,
        input  rf_read_data_1, rf_read_data_2,
        input  wb_write_enable, wb_write_select, wb_write_data,
        input  flush, ex_hold,
        output stall,
        output ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
               ex_mem_read, ex_reg_write
    );

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_imm, id_alu_op, id_mem_read, id_reg_write,
        input  rf_read_sel_1, rf_read_sel_2,
        output rf_read_data_1, rf_read_data_2,
        output wb_write_enable, wb_write_select, wb_write_data,
        output flush, ex_hold,
        input  stall,
        input  ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op,
               ex_mem_read, ex_reg_write
    );

endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use detection against the instruction in EX and the
// resulting front-end stall request.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH
) (
    input  logic                      id_valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt_i,
    input  logic                      ex_valid_i,
    input  logic                      ex_mem_read_i,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rt_i,
    input  logic                      flush_i,
    input  logic                      ex_hold_i,
    output logic                      load_use_o,
    output logic                      stall_o
);

    logic ex_rt_nonzero;
    logic ex_rt_match;

    assign ex_rt_nonzero = (ex_rt_i != REG_ADDR_WIDTH'(REG_ZERO));
    assign ex_rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);

    assign load_use_o = id_valid_i & ex_valid_i & ex_mem_read_i & ex_rt_nonzero & ex_rt_match;

    // A taken branch kills the dependent instruction, so it need not wait.
    assign stall_o = (load_use_o & ~flush_i) | ex_hold_i;

endmodule

// File: rtl/id_ex_stage.sv
// Operand fetch with WB-to-ID bypass and the ID/EX pipeline register,
// including load-use bubbles, branch flush and downstream hold.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = pipe_pkg::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = pipe_pkg::REG_ADDR_WIDTH,
    parameter int ALU_OP_WIDTH   = pipe_pkg::ALU_OP_WIDTH
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic                      valid;
        logic [DATA_WIDTH-1:0]     op_a;
        logic [DATA_WIDTH-1:0]     op_b;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [ALU_OP_WIDTH-1:0]   alu_op;
        logic                      mem_read;
        logic                      reg_write;
    } ex_fields_t;

    ex_fields_t            ex_q;
    ex_fields_t            ex_d;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  load_use;

    // The register file commits on the same edge we capture, so its read
    // port is stale for the register WB is writing this cycle.
    function automatic logic [DATA_WIDTH-1:0] select_operand(
        input logic [REG_ADDR_WIDTH-1:0] sel,
        input logic [DATA_WIDTH-1:0]     rf_data,
        input logic                      wb_en,
        input logic [REG_ADDR_WIDTH-1:0] wb_sel,
        input logic [DATA_WIDTH-1:0]     wb_data
    );
        if (sel == REG_ADDR_WIDTH'(REG_ZERO)) begin
            return '0;
        end else if (wb_en && (wb_sel == sel)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    assign bus.rf_read_sel_1 = bus.id_rs;
    assign bus.rf_read_sel_2 = bus.id_rt;

    assign op_a = select_operand(bus.id_rs, bus.rf_read_data_1,
                                 bus.wb_write_enable, bus.wb_write_select, bus.wb_write_data);
    assign op_b = select_operand(bus.id_rt, bus.rf_read_data_2,
                                 bus.wb_write_enable, bus.wb_write_select, bus.wb_write_data);

    hazard_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard_unit (
        .id_valid_i    (bus.id_valid),
        .id_rs_i       (bus.id_rs),
        .id_rt_i       (bus.id_rt),
        .ex_valid_i    (ex_q.valid),
        .ex_mem_read_i (ex_q.mem_read),
        .ex_rt_i       (ex_q.rt),
        .flush_i       (bus.flush),
        .ex_hold_i     (bus.ex_hold),
        .load_use_o    (load_use),
        .stall_o       (bus.stall)
    );

    // NOTE: ex_d is given a full default before any branch so no path through
    // this block leaves it unassigned and a latch is never inferred.
    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.ex_hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = bus.id_valid;
            ex_d.op_a      = op_a;
            ex_d.op_b      = op_b;
            ex_d.imm       = bus.id_imm;
            ex_d.rs        = bus.id_rs;
            ex_d.rt        = bus.id_rt;
            ex_d.rd        = bus.id_rd;
            ex_d.alu_op    = bus.id_alu_op;
            ex_d.mem_read  = bus.id_mem_read  & bus.id_valid;
            ex_d.reg_write = bus.id_reg_write & bus.id_valid;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_op_a      = ex_q.op_a;
    assign bus.ex_op_b      = ex_q.op_b;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_rs        = ex_q.rs;
    assign bus.ex_rt        = ex_q.rt;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.ex_alu_op    = ex_q.alu_op;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_reg_write = ex_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, bypass, load-use, flush,
// hold and zero-register cases with hand-computed expectations.
module tb_id_ex_stage;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] imm, input logic [3:0] op,
                          input logic mr, input logic rw);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_imm       = imm;
        bus.id_alu_op    = op;
        bus.id_mem_read  = mr;
        bus.id_reg_write = rw;
    endtask

    task automatic set_rf(input logic [31:0] d1, input logic [31:0] d2);
        bus.rf_read_data_1 = d1;
        bus.rf_read_data_2 = d2;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] sel, input logic [31:0] data);
        bus.wb_write_enable = en;
        bus.wb_write_select = sel;
        bus.wb_write_data   = data;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush   = 1'b0;
        bus.ex_hold = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h5, ALU_ADD, 1'b0, 1'b1);
        set_rf(32'h11, 32'h22);
        set_wb(1'b0, 5'd0, 32'h0);

        // Reset held two cycles with a valid instruction in ID
        tick();
        tick();
        check("rst_valid",     bus.ex_valid, 0);
        check("rst_op_a",      bus.ex_op_a, 0);
        check("rst_imm",       bus.ex_imm, 0);
        check("rst_rd",        bus.ex_rd, 0);
        check("rst_reg_write", bus.ex_reg_write, 0);
        check("rst_stall",     bus.stall, 0);
        check("rf_sel_1",      bus.rf_read_sel_1, 1);
        check("rf_sel_2",      bus.rf_read_sel_2, 2);

        // First instruction after reset appears one cycle later
        rst = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h1234, ALU_SUB, 1'b0, 1'b1);
        tick();
        check("a_valid",  bus.ex_valid, 1);
        check("a_op_a",   bus.ex_op_a, 32'h11);
        check("a_op_b",   bus.ex_op_b, 32'h22);
        check("a_imm",    bus.ex_imm, 32'h1234);
        check("a_rd",     bus.ex_rd, 3);
        check("a_alu_op", bus.ex_alu_op, ALU_SUB);
        check("a_rw",     bus.ex_reg_write, 1);

        // WB bypass of r10 over a stale register file read
        set_id(1'b1, 5'd10, 5'd11, 5'd12, 32'h0, ALU_ADD, 1'b0, 1'b1);
        set_rf(32'h0, 32'h33);
        set_wb(1'b1, 5'd10, 32'h0AB5);
        tick();
        check("byp_op_a", bus.ex_op_a, 32'h0AB5);
        check("byp_op_b", bus.ex_op_b, 32'h33);

        // r0 never bypasses and never reads the register file value
        set_id(1'b1, 5'd0, 5'd11, 5'd12, 32'h0, ALU_ADD, 1'b0, 1'b1);
        set_rf(32'h77, 32'h33);
        set_wb(1'b1, 5'd0, 32'hFFFF);
        tick();
        check("r0_op_a", bus.ex_op_a, 0);
        set_wb(1'b0, 5'd0, 32'h0);

        // Load r9, then a dependent reader: one bubble, then bypassed operand
        set_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h4, ALU_ADD, 1'b1, 1'b1);
        set_rf(32'h100, 32'h0);
        tick();
        check("ld_mem_read", bus.ex_mem_read, 1);
        check("ld_rt",       bus.ex_rt, 9);
        set_id(1'b1, 5'd9, 5'd2, 5'd5, 32'h8, ALU_OR, 1'b0, 1'b1);
        set_rf(32'h0, 32'h22);
        #1;
        check("lu_stall", bus.stall, 1);
        tick();
        check("lu_bubble_valid", bus.ex_valid, 0);
        check("lu_bubble_mr",    bus.ex_mem_read, 0);
        check("lu_bubble_op_a",  bus.ex_op_a, 0);
        check("lu_stall_clear",  bus.stall, 0);
        set_wb(1'b1, 5'd9, 32'hBEEF);
        tick();
        check("lu_valid", bus.ex_valid, 1);
        check("lu_op_a",  bus.ex_op_a, 32'hBEEF);
        check("lu_rd",    bus.ex_rd, 5);
        set_wb(1'b0, 5'd0, 32'h0);

        // Flush coinciding with load-use: no stall, bubble
        set_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h4, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd2, 5'd5, 32'h8, ALU_OR, 1'b0, 1'b1);
        bus.flush = 1'b1;
        #1;
        check("flu_stall", bus.stall, 0);
        tick();
        check("flu_valid", bus.ex_valid, 0);
        check("flu_rw",    bus.ex_reg_write, 0);
        bus.flush = 1'b0;

        // Flush wins over hold
        set_id(1'b1, 5'd1, 5'd2, 5'd4, 32'h9, ALU_AND, 1'b0, 1'b1);
        tick();
        check("fh_pre_valid", bus.ex_valid, 1);
        bus.flush   = 1'b1;
        bus.ex_hold = 1'b1;
        #1;
        check("fh_stall", bus.stall, 1);
        tick();
        check("fh_valid", bus.ex_valid, 0);
        check("fh_rw",    bus.ex_reg_write, 0);
        bus.flush   = 1'b0;
        bus.ex_hold = 1'b0;

        // Hold for three cycles with changing ID inputs, then release
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h55, ALU_XOR, 1'b0, 1'b1);
        set_rf(32'hA1, 32'hA2);
        tick();
        check("h_pre_rd", bus.ex_rd, 6);
        bus.ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'd7, 5'd8, 5'(7 + i), 32'(i + 100), ALU_SLT, 1'b0, 1'b1);
            set_rf(32'(i), 32'(i));
            #1;
            check("h_stall", bus.stall, 1);
            tick();
            check("h_rd",   bus.ex_rd, 6);
            check("h_imm",  bus.ex_imm, 32'h55);
            check("h_op_a", bus.ex_op_a, 32'hA1);
        end
        bus.ex_hold = 1'b0;
        set_id(1'b1, 5'd3, 5'd4, 5'd20, 32'h66, ALU_SLL, 1'b0, 1'b1);
        set_rf(32'h0, 32'hA2);
        set_wb(1'b1, 5'd3, 32'hC3);
        tick();
        check("hr_rd",   bus.ex_rd, 20);
        check("hr_op_a", bus.ex_op_a, 32'hC3);
        check("hr_imm",  bus.ex_imm, 32'h66);
        set_wb(1'b0, 5'd0, 32'h0);

        // Load into r0 followed by an r0 reader: no hazard
        set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h4, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 32'h1, ALU_ADD, 1'b0, 1'b1);
        set_rf(32'h99, 32'h98);
        #1;
        check("z_stall", bus.stall, 0);
        tick();
        check("z_valid", bus.ex_valid, 1);
        check("z_op_a",  bus.ex_op_a, 0);
        check("z_op_b",  bus.ex_op_b, 0);

        // Reset in the middle of a load-use stall
        set_id(1'b1, 5'd1, 5'd9, 5'd0, 32'h4, ALU_ADD, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd9, 5'd2, 5'd5, 32'h8, ALU_OR, 1'b0, 1'b1);
        #1;
        check("rs_stall_pre", bus.stall, 1);
        rst = 1'b1;
        tick();
        check("rs_valid", bus.ex_valid, 0);
        check("rs_stall", bus.stall, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Operand-fetch and ID/EX pipeline register of the pipelined datapath; sits directly downstream of nbit_register_file.
- Drives the register file read selects from the decoded instruction, captures read_data_1/read_data_2 with WB-to-ID bypass, and registers the operands plus control into the EX stage.
- Detects load-use hazards: stalls IF/ID and inserts a bubble into EX. Also supports branch flush and a downstream hold.

Parameters:
DATA_WIDTH, 32, operand/immediate width
REG_ADDR_WIDTH, 5, register select width (2**REG_ADDR_WIDTH registers)
ALU_OP_WIDTH, 4, ALU operation code width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  IF/ID holds a valid instruction
id_rs  input  REG_ADDR_WIDTH  source register A
id_rt  input  REG_ADDR_WIDTH  source register B / load destination
id_rd  input  REG_ADDR_WIDTH  destination register
id_imm  input  DATA_WIDTH  sign-extended immediate
id_alu_op  input  ALU_OP_WIDTH  decoded ALU op
id_mem_read  input  1  instruction is a load
id_reg_write  input  1  instruction writes a register
rf_read_sel_1  output  REG_ADDR_WIDTH  to register file read_sel_1
rf_read_sel_2  output  REG_ADDR_WIDTH  to register file read_sel_2
rf_read_data_1  input  DATA_WIDTH  from register file read_data_1
rf_read_data_2  input  DATA_WIDTH  from register file read_data_2
wb_write_enable  input  1  WB stage writing register file this cycle
wb_write_select  input  REG_ADDR_WIDTH  WB destination
wb_write_data  input  DATA_WIDTH  WB data
flush  input  1  branch taken; kill instruction entering EX
ex_hold  input  1  downstream stall; freeze EX register
stall  output  1  freeze PC and IF/ID (combinational)
ex_valid, ex_op_a, ex_op_b, ex_imm, ex_rs, ex_rt, ex_rd, ex_alu_op, ex_mem_read, ex_reg_write  output  (widths as ID counterparts; op_a/op_b DATA_WIDTH)  registered EX-stage fields

Behaviour:
- rf_read_sel_1 = id_rs, rf_read_sel_2 = id_rt, both combinational.
- Operand select, per operand: select==0 -> 0. Otherwise, if wb_write_enable and wb_write_select==select -> wb_write_data (the register file writes at the edge, so a same-cycle read is stale). Otherwise -> rf data.
- load_use = id_valid & ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
- stall = (load_use & ~flush) | ex_hold.
- Registered update, priority high to low:
  1. rst: all ex_* outputs = 0. This includes ex_valid=0 and ex_mem_read=ex_reg_write=0.
  2. flush: bubble, i.e. ex_valid=0 and ex_mem_read=ex_reg_write=0. Flush overrides ex_hold and load_use.
  3. ex_hold: all ex_* unchanged.
  4. load_use: bubble; IF/ID is held by stall and re-presents the instruction next cycle.
  5. Otherwise: load ID fields and bypassed operands. ex_valid=id_valid. Control bits are gated by id_valid.
- Latency: exactly 1 cycle ID->EX. A load followed by a dependent instruction costs exactly 1 bubble.
- A bubble zeroes all data fields, giving a deterministic compare in simulation.
- Reset mid-stall: the next cycle has ex_valid=0, so load_use=0 and stall=ex_hold.
- Bypass applies on hold release too: the operand is recomputed from current WB inputs on the capture cycle.

Decomposition:
- Shared package pipe_pkg: DATA_WIDTH/REG_ADDR_WIDTH/ALU_OP_WIDTH defaults, REG_ZERO constant, ALU op encodings.
- One sub-module, hazard_unit: combinational load_use and stall. Operand bypass and the EX register stay in id_ex_stage.

Test Plan:
1. Reset: assert rst 2 cycles with id_valid=1 -> all ex_* = 0 and stall=0. Release -> the next ID instruction appears 1 cycle later.
2. Bypass: wb writes r10=0x0AB5 while ID reads rs=10 with stale rf data 0 -> ex_op_a=0x0AB5. The r0 case: wb writes r0=0xFFFF, ID reads rs=0 -> ex_op_a=0.
3. Load-use: load rt=9 in EX, ID has rs=9 -> stall=1 for 1 cycle and ex_valid=0 next cycle. The instruction then enters with op_a = the WB-bypassed load value.
4. Flush with load_use in the same cycle -> stall=0 and a bubble next cycle. Flush with ex_hold=1 -> bubble (flush wins).
5. ex_hold=1 for 3 cycles with changing ID inputs -> ex_* frozen and stall=1 throughout. Release -> the current ID is captured.
6. Load with rt=0 followed by a reader of r0 -> no stall and operand=0.
